// File: rtl/neuron_tree_sched.sv
// neuron_tree_sched: sequences operand batches through the shared adder tree and accumulates the membrane potential.
// Optional saturation of the accumulator is enabled by defining ACC_SAT_EN, which also adds the sat_flag port.
module neuron_tree_sched #(
  parameter int N      = 8,
  parameter int NUM_IN = 8,
  parameter int SETTLE = 2,
  parameter int ACC_W  = 16,
  parameter int BW     = 4
) (
`ifdef ACC_SAT_EN
  output logic                  sat_flag,
`endif
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BW-1:0]         cfg_batches,
  input  logic [ACC_W-1:0]      cfg_thresh,
  input  logic                  op_valid,
  input  logic [NUM_IN*N-1:0]   op_data,
  output logic                  op_ready,
  output logic [NUM_IN*N-1:0]   tree_op,
  input  logic [N+2:0]          tree_sum,
  output logic [ACC_W-1:0]      acc,
  output logic                  busy,
  output logic                  done,
  output logic                  spike
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CAPT, S_FIRE} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     batch_cnt, batches;
  logic [ACC_W-1:0]  thresh, acc_nx;
  logic              last;
  assign op_ready = state == S_LOAD;
  assign busy     = state != S_IDLE;
  assign last     = batch_cnt + BW'(1) == batches;
`ifdef ACC_SAT_EN
  logic [ACC_W:0] sum;
  assign sum    = {1'b0, acc} + (ACC_W+1)'(tree_sum);
  assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nx = acc + ACC_W'(tree_sum);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      batch_cnt <= '0;
      batches   <= '0;
      thresh    <= '0;
      acc       <= '0;
      tree_op   <= '0;
      done      <= 1'b0;
      spike     <= 1'b0;
`ifdef ACC_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      spike <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          batches   <= cfg_batches == '0 ? BW'(1) : cfg_batches;
          thresh    <= cfg_thresh;
          acc       <= '0;
          batch_cnt <= '0;
`ifdef ACC_SAT_EN
          sat_flag  <= 1'b0;
`endif
          state     <= S_LOAD;
        end
        // tree_op only changes on acceptance so the tree inputs stay quiet otherwise
        S_LOAD: if (op_valid) begin
          tree_op <= op_data;
          cnt     <= CW'(SETTLE - 1);
          state   <= S_SETTLE;
        end
        S_SETTLE: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= S_CAPT;
        end
        S_CAPT: begin
          acc       <= acc_nx;
          batch_cnt <= batch_cnt + BW'(1);
`ifdef ACC_SAT_EN
          if (sum[ACC_W]) sat_flag <= 1'b1;
`endif
          state     <= last ? S_FIRE : S_LOAD;
          done      <= last;
          spike     <= last && acc_nx >= thresh;
        end
        S_FIRE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_tree_sched.sv
// tb_neuron_tree_sched: randomized scoreboard bench; a reference model predicts acc, spike, sat and done timing per evaluation.
module tb_neuron_tree_sched;
  localparam int N = 8, NI = 8, SET = 2, AW = 12, BW = 4;
  logic clk = 0, rst_n = 0, start = 0, op_valid = 0;
  logic [BW-1:0] cfg_batches = '0;
  logic [AW-1:0] cfg_thresh = '0;
  logic [NI*N-1:0] op_data = '0, tree_op;
  logic [N+2:0] tree_sum;
  logic op_ready, busy, done, spike, sat_flag;
  logic [AW-1:0] acc;
  int compared = 0, mismatched = 0, cyc = 0;
  typedef struct {int acc; bit spike; bit sat; int cyc;} exp_t;
  exp_t q[$];
  logic [63:0] vecs [16];
  int stl [16];
`ifndef ACC_SAT_EN
  assign sat_flag = 1'b0;
`endif

  neuron_tree_sched #(.N(N), .NUM_IN(NI), .SETTLE(SET), .ACC_W(AW), .BW(BW)) dut (
`ifdef ACC_SAT_EN
    .sat_flag(sat_flag),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_batches(cfg_batches), .cfg_thresh(cfg_thresh),
    .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready), .tree_op(tree_op), .tree_sum(tree_sum),
    .acc(acc), .busy(busy), .done(done), .spike(spike)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adder tree stand-in: plain sum of the driven operands
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < NI; i++) tree_sum += (N+3)'(tree_op[i*N +: N]);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("acc", 64'(acc), 64'(e.acc));
        chk("spike", 64'(spike), 64'(e.spike));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef ACC_SAT_EN
        chk("sat_flag", 64'(sat_flag), 64'(e.sat));
`endif
      end
    end else if (spike) chk("spike_without_done", 1, 0);
  end

  task automatic run_eval(input logic [BW-1:0] b, input logic [AW-1:0] th, input bit poke);
    int eb, a, s, tot, c0, n;
    bit sat;
    exp_t e;
    eb = (b == 0) ? 1 : int'(b);
    a = 0; sat = 0; tot = 0;
    for (int i = 0; i < eb; i++) begin
      s = 0;
      for (int j = 0; j < NI; j++) s += int'(vecs[i][j*N +: N]);
      a += s;
      if (a >= 2**AW) begin
`ifdef ACC_SAT_EN
        a = 2**AW - 1; sat = 1;
`else
        a -= 2**AW;
`endif
      end
      tot += stl[i];
    end
    @(posedge clk); #1;
    cfg_batches = b; cfg_thresh = th; start = 1; c0 = cyc;
    e.acc = a; e.spike = (a >= int'(th)); e.sat = sat; e.cyc = c0 + 1 + eb*(SET+2) + tot;
    q.push_back(e);
    @(posedge clk); #1;
    start = 0; cfg_batches = BW'($urandom); cfg_thresh = AW'($urandom);
    @(negedge clk);
    for (int i = 0; i < eb; i++) begin
      n = 0;
      while (!op_ready && n < 100) begin @(negedge clk); n++; end
      if (!op_ready) begin chk("ready_timeout", 0, 1); return; end
      for (int k = 0; k < stl[i]; k++) begin
        @(posedge clk); #1;
        if (poke && k == 0) start = 1;
        @(negedge clk);
        chk("ready_during_stall", 64'(op_ready), 1);
        if (i > 0) chk("tree_op_hold", tree_op, vecs[i-1]);
      end
      op_valid = 1; op_data = vecs[i];
      @(posedge clk); #1;
      op_valid = 0; start = 0; op_data = {$urandom, $urandom};
      @(negedge clk);
      chk("tree_op_load", tree_op, vecs[i]);
    end
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("busy_clear", 64'(busy), 0);
    chk("acc_hold", 64'(acc), 64'(a));
  endtask

  task automatic fill(input logic [63:0] v, input int nb);
    for (int i = 0; i < 16; i++) begin vecs[i] = v; stl[i] = 0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_acc", 64'(acc), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_tree_op", tree_op, 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_op_ready", 64'(op_ready), 0);
    chk("rst_sat", 64'(sat_flag), 0);
    rst_n = 1;
    // abort an evaluation mid-settle
    @(posedge clk); #1; cfg_batches = 2; start = 1;
    @(posedge clk); #1; start = 0; op_valid = 1; op_data = 64'h0123456789ABCDEF;
    @(posedge clk); #1; op_valid = 0;
    @(negedge clk);
    chk("abort_tree_op_loaded", tree_op, 64'h0123456789ABCDEF);
    chk("abort_busy_before", 64'(busy), 1);
    rst_n = 0; #1;
    chk("abort_acc", 64'(acc), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_tree_op", tree_op, 0);
    chk("abort_done", 64'(done), 0);
    @(negedge clk); rst_n = 1;
    repeat (20) @(negedge clk);
    chk("abort_idle", 64'(busy), 0);
    fill(64'h00FF00FF00FF00FF, 4);
    run_eval(4, 4000, 0);
    run_eval(4, 4081, 0);
    fill(64'hFFFFFFFFFFFFFFFF, 1);
    run_eval(0, 2040, 0);
    fill(64'h00FF00FF00FF00FF, 4);
    stl[1] = 3;
    run_eval(4, 4000, 1);
    fill(64'h00000000FFFFFFFF, 5);
    run_eval(5, 1005, 0);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) begin
        vecs[i] = {$urandom, $urandom};
        stl[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      run_eval(BW'($urandom_range(0, 6)), AW'($urandom), r[0]);
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/neuron_tree_sched.md
Name: neuron_tree_sched

Overview:
- Sequencer for the shared 8-operand transmission-gate full-adder tree (8x8-bit operands in, 11-bit sum out) used in the digital neuron.
- Accepts operand vectors from an upstream requester via a valid/ready handshake and drives them onto the tree.
- Waits a programmable settling interval for the RC-modelled tree, then captures the sum into a wide accumulator (membrane potential).
- After a configured number of batches, compares the accumulator with a threshold and emits a spike pulse plus done.

Parameters:
- N, 8, operand width in bits.
- NUM_IN, 8, operands per tree pass; tree sum width is N+3.
- SETTLE, 2, clock cycles (>=1) the tree output is left to settle before capture.
- ACC_W, 16, accumulator width (>= N+3).
- BW, 4, width of the batch-count config port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a neuron evaluation; sampled only in IDLE.
- cfg_batches  in  BW  number of tree passes per evaluation; 0 is treated as 1; latched on start.
- cfg_thresh  in  ACC_W  firing threshold; latched on start.
- op_valid  in  1  operand vector valid.
- op_data  in  NUM_IN*N  operand vector; operand i at bits [i*N +: N].
- op_ready  out  1  scheduler accepts op_data.
- tree_op  out  NUM_IN*N  registered operands driving the adder-tree A/B inputs.
- tree_sum  in  N+3  adder-tree result.
- acc  out  ACC_W  accumulator value.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of evaluation.
- spike  out  1  one-cycle pulse coincident with done when acc >= threshold.
- sat_flag  out  1  overflow indicator; exists only with ACC_SAT_EN.

Behaviour:
- Reset: all outputs 0, state IDLE, batch counter 0, latched config 0. Reset is asynchronous and aborts any evaluation in progress; no done or spike is issued for the aborted evaluation.
- States: IDLE, LOAD, SETTLE, CAPT, FIRE.
- IDLE: if start=1 at a rising edge, latch cfg_batches (0 becomes 1) and cfg_thresh, clear acc and the batch counter, then go to LOAD. acc otherwise holds the previous result.
- LOAD: op_ready=1 (combinational on state only). On op_valid&op_ready, tree_op<=op_data, load the settle counter with SETTLE-1, go to SETTLE. With no valid, stay in LOAD indefinitely.
- SETTLE: decrement the counter each cycle; at 0, go to CAPT. Total of SETTLE cycles in this state. tree_op is stable throughout.
- CAPT: acc<=acc+zero-extended tree_sum and batch_cnt<=batch_cnt+1. If the incremented count equals the latched batch count, go to FIRE, else go to LOAD.
- FIRE: done=1 and spike=(acc>=thresh), unsigned compare using the final acc. Return to IDLE the next edge.
- Per-batch cost with op_valid held high: 1 (LOAD) + SETTLE + 1 (CAPT) cycles. done is high in cycle 1+B*(SETTLE+2) counted after the start edge.
- tree_op is never cleared outside reset; it holds its last value so the tree does not toggle (power).
- start while busy is ignored. op_ready=0 outside LOAD, so op_valid outside LOAD has no effect.
- Without ACC_SAT_EN, acc wraps modulo 2^ACC_W.

Optional Feature:
- ACC_SAT_EN defined: addition in CAPT saturates at 2^ACC_W-1. sat_flag is set on the first overflow, holds until the next start in IDLE, and resets to 0.
- ACC_SAT_EN undefined: the sum wraps and the sat_flag port is absent.

Test Plan:
- Reset mid-SETTLE (rst_n low 1 cycle) -> acc=0, busy=0, tree_op=0, no done or spike.
- SETTLE=2, cfg_batches=4, thresh=4000, operands {FF,00,FF,00,FF,00,FF,00}, op_valid held high -> per-pass tree_sum=0x3FC, acc=4080, done and spike high in cycle 17 after start.
- Same stimulus with thresh=4081 -> acc=4080, done=1, spike=0.
- cfg_batches=0, one vector of all FF -> exactly one pass, acc=2040, done in cycle 5.
- op_valid deasserted for 3 cycles in LOAD of batch 2 -> op_ready stays high, tree_op unchanged, done delayed by exactly 3 cycles, acc unchanged vs the no-stall run; start pulsed while busy is ignored.
- ACC_W=12, 5 batches of sum 1020 -> with ACC_SAT_EN: acc=4095, sat_flag=1; without: acc=1004.
